alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//   Control-side counterpart of the ALU: accepts one 16-bit instruction word at a time,
//   decodes it, reads operands from the register file, and drives a/b/op into the ALU.
//   It captures the ALU result, writes it back, and updates the Z/N flags.
//   Sits between instruction fetch and the datapath (register file + alu).
// PARAMETERS
//   WORD_SIZE  16  datapath width; alu_a/alu_b/alu_out/rf data widths
//   NUM_REGS   8   register count; RADDR_W = $clog2(NUM_REGS), instr fields are 3 bits (NUM_REGS<=8)
// PORTS
//   clk          in   1          clock, all state on rising edge
//   rst          in   1          asynchronous reset, active-high
//   instr_valid  in   1          instruction word present on instr
//   instr_ready  out  1          sequencer can accept; transfer when valid&&ready
//   instr        in   16         [15:11] opcode, [10:8] Rx (dest/src A), [7:5] Ry (src B), [4:0] ignored
//   rf_ra_addr   out  RADDR_W    register file read port A address (= Rx)
//   rf_rb_addr   out  RADDR_W    register file read port B address (= Ry)
//   rf_ra_data   in   WORD_SIZE  combinational read data A
//   rf_rb_data   in   WORD_SIZE  combinational read data B
//   alu_a        out  WORD_SIZE  ALU operand a (registered)
//   alu_b        out  WORD_SIZE  ALU operand b (registered)
//   alu_op       out  4          ALU opcode: ADD=0 SUB=1 LSL=2 ASR=3 LSR=4 AND=5 OR=6 XOR=7 EQUAL=8
//   alu_out      in   WORD_SIZE  ALU result (combinational from alu_a/alu_b/alu_op)
//   rf_we        out  1          one-cycle write-enable pulse
//   rf_waddr     out  RADDR_W    write address (= Rx)
//   rf_wdata     out  WORD_SIZE  write data (registered result)
//   flag_z       out  1          result == 0, from last flag-updating instruction
//   flag_n       out  1          result[WORD_SIZE-1], same
//   illegal      out  1          one-cycle pulse: undefined opcode dropped
// BEHAVIOUR
//   Reset: state IDLE; instr_ready=1; all other outputs 0 (alu_op=0, flags 0, rf_we=0, illegal=0).
//   Reset mid-instruction aborts it: no rf_we, flags unchanged from reset value 0.
//   Opcodes: 00001 ADD, 00011 SUB, 00100 AND, 00101 OR, 00110 XOR, 00111 CMP (SUB, no writeback),
//     01000 MOV (op=OR, b=0), 01001 SEQ (EQUAL), 11010 LSL, 11011 LSR, 11100 ASR; others illegal.
//   FSM: IDLE -> READ -> EXEC -> WB -> IDLE.
//     IDLE: instr_ready=1; on valid&&ready latch instr; -> READ (illegal opcode: illegal=1 next cycle, stay IDLE).
//     READ: instr_ready=0; rf_ra/rb_addr driven from latched Rx/Ry; register rf data into alu_a/alu_b and decoded alu_op.
//     EXEC: alu_a/b/op stable; register alu_out into result.
//     WB: rf_we=1 (except CMP), rf_waddr=Rx, rf_wdata=result; Z/N updated for all except MOV.
//   Latency: handshake at edge k -> rf_we high in cycle k+3; flags valid from k+4; next accept at edge k+4.
//   Throughput: one instruction per 4 cycles; instr ignored while instr_ready=0.
//   Arithmetic: modulo 2^WORD_SIZE wrap; no carry/overflow flags.
//   Shifts: amount = full b operand, as the ALU performs it.
//   Rx==Ry legal: both ports read the same register.
//   rf_ra_addr/rf_rb_addr hold the last latched values outside READ.
//   alu_a/b/op hold the last values outside READ.
// TESTING
//   Reset mid-EXEC of ADD -> no rf_we; instr_ready=1, flags 0 the cycle after rst falls.
//   R1=0x0005, R2=0x0003, ADD R1,R2 (0x0940) -> rf_we at k+3, waddr=1, wdata=0x0008, Z=0 N=0.
//   R1=0x0003, R2=0x0005, SUB R1,R2 -> wdata=0xFFFE, N=1; then CMP R1,R1 -> no rf_we, Z=1 N=0.
//   R3=0xFFFF, R4=0x0001, ADD R3,R4 -> wdata=0x0000 (wrap), Z=1.
//   Opcode 11111 -> illegal pulse 1 cycle, no rf_we, instr_ready stays 1; next valid ADD completes normally.
//   Back-to-back valid held high for 3 instructions -> accepts exactly at edges k, k+4, k+8.

Source files
------------

// File: rtl/alu_sequencer.sv
// Instruction sequencer for the ALU datapath: accepts one instruction word, reads the
// register file, drives the ALU, writes the result back and maintains the Z/N flags.
module alu_sequencer #(
    parameter int WORD_SIZE = 16,
    parameter int NUM_REGS  = 8,
    localparam int RADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [15:0]          instr,
    output logic [RADDR_W-1:0]   rf_ra_addr,
    output logic [RADDR_W-1:0]   rf_rb_addr,
    input  logic [WORD_SIZE-1:0] rf_ra_data,
    input  logic [WORD_SIZE-1:0] rf_rb_data,
    output logic [WORD_SIZE-1:0] alu_a,
    output logic [WORD_SIZE-1:0] alu_b,
    output logic [3:0]           alu_op,
    input  logic [WORD_SIZE-1:0] alu_out,
    output logic                 rf_we,
    output logic [RADDR_W-1:0]   rf_waddr,
    output logic [WORD_SIZE-1:0] rf_wdata,
    output logic                 flag_z,
    output logic                 flag_n,
    output logic                 illegal
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_LSL = 4'd2;
    localparam logic [3:0] OP_ASR = 4'd3;
    localparam logic [3:0] OP_LSR = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_EQ  = 4'd8;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    typedef struct packed {
        logic       legal;
        logic       wb;      // write result back to Rx
        logic       fl;      // update Z/N
        logic       zero_b;  // force operand b to zero
        logic [3:0] op;
    } dec_t;

    function automatic dec_t decode(input logic [4:0] opc);
        dec_t d;
        d = '{legal: 1'b1, wb: 1'b1, fl: 1'b1, zero_b: 1'b0, op: OP_ADD};
        case (opc)
            5'b00001: d.op = OP_ADD;
            5'b00011: d.op = OP_SUB;
            5'b00100: d.op = OP_AND;
            5'b00101: d.op = OP_OR;
            5'b00110: d.op = OP_XOR;
            5'b00111: begin d.op = OP_SUB; d.wb = 1'b0; end
            5'b01000: begin d.op = OP_OR; d.zero_b = 1'b1; d.fl = 1'b0; end
            5'b01001: d.op = OP_EQ;
            5'b11010: d.op = OP_LSL;
            5'b11011: d.op = OP_LSR;
            5'b11100: d.op = OP_ASR;
            default:  d.legal = 1'b0;
        endcase
        return d;
    endfunction

    state_t                 state_q, state_d;
    logic [4:0]             opc_q, opc_d;
    logic [RADDR_W-1:0]     rx_q, rx_d, ry_q, ry_d;
    logic [WORD_SIZE-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]             alu_op_q, alu_op_d;
    logic [WORD_SIZE-1:0]   result_q, result_d;
    logic                   flag_z_q, flag_z_d, flag_n_q, flag_n_d;
    logic                   illegal_q, illegal_d;
    dec_t                   in_dec, cur_dec;
    logic                   unused_bits;

    assign unused_bits = ^instr[4:0];
    assign in_dec      = decode(instr[15:11]);
    assign cur_dec     = decode(opc_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            opc_q     <= '0;
            rx_q      <= '0;
            ry_q      <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            result_q  <= '0;
            flag_z_q  <= 1'b0;
            flag_n_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            rx_q      <= rx_d;
            ry_q      <= ry_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            result_q  <= result_d;
            flag_z_q  <= flag_z_d;
            flag_n_q  <= flag_n_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        opc_d       = opc_q;
        rx_d        = rx_q;
        ry_d        = ry_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        result_d    = result_q;
        flag_z_d    = flag_z_q;
        flag_n_d    = flag_n_q;
        illegal_d   = 1'b0;
        instr_ready = 1'b0;
        rf_we       = 1'b0;
        case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    opc_d = instr[15:11];
                    rx_d  = instr[8 +: RADDR_W];
                    ry_d  = instr[5 +: RADDR_W];
                    // Undefined opcodes are dropped here; the sequencer stays ready.
                    if (in_dec.legal) state_d = READ;
                    else              illegal_d = 1'b1;
                end
            end
            READ: begin
                alu_a_d  = rf_ra_data;
                alu_b_d  = cur_dec.zero_b ? '0 : rf_rb_data;
                alu_op_d = cur_dec.op;
                state_d  = EXEC;
            end
            EXEC: begin
                result_d = alu_out;
                state_d  = WB;
            end
            WB: begin
                rf_we = cur_dec.wb;
                if (cur_dec.fl) begin
                    flag_z_d = (result_q == '0);
                    flag_n_d = result_q[WORD_SIZE-1];
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rf_ra_addr = rx_q;
    assign rf_rb_addr = ry_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rf_waddr   = rx_q;
    assign rf_wdata   = result_q;
    assign flag_z     = flag_z_q;
    assign flag_n     = flag_n_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: register file and ALU environment, instruction-level reference
// model with per-cycle comparison, directed literal cases and a randomized instruction stream.
module tb_alu_sequencer;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          instr_valid;
    logic          instr_ready;
    logic [15:0]   instr;
    logic [2:0]    rf_ra_addr, rf_rb_addr, rf_waddr;
    logic [W-1:0]  rf_ra_data, rf_rb_data, alu_a, alu_b, alu_out, rf_wdata;
    logic [3:0]    alu_op;
    logic          rf_we, flag_z, flag_n, illegal;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
        .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_out(alu_out), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .flag_z(flag_z), .flag_n(flag_n), .illegal(illegal)
    );

    // Environment: register file and ALU
    logic [W-1:0] rf [8];
    logic [W-1:0] m_reg [8];

    function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [3:0] op);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a << b;
            4'd3: return $signed(a) >>> b;
            4'd4: return a >> b;
            4'd5: return a & b;
            4'd6: return a | b;
            4'd7: return a ^ b;
            4'd8: return (a == b) ? 16'd1 : 16'd0;
            default: return 16'd0;
        endcase
    endfunction

    assign rf_ra_data = rf[rf_ra_addr];
    assign rf_rb_data = rf[rf_rb_addr];
    assign alu_out    = alu_f(alu_a, alu_b, alu_op);

    // Instruction-level reference: what one instruction does to registers and flags
    typedef struct packed {
        logic         legal;
        logic         wb;
        logic         fl;
        logic [3:0]   aop;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic [W-1:0] res;
    } mres_t;

    function automatic mres_t model_fn(input logic [4:0] opc, input logic [W-1:0] x,
                                       input logic [W-1:0] y);
        mres_t r;
        r = '0;
        r.legal = 1'b1; r.wb = 1'b1; r.fl = 1'b1; r.ea = x; r.eb = y;
        case (opc)
            5'b00001: begin r.aop = 4'd0; r.res = x + y; end
            5'b00011: begin r.aop = 4'd1; r.res = x - y; end
            5'b00100: begin r.aop = 4'd5; r.res = x & y; end
            5'b00101: begin r.aop = 4'd6; r.res = x | y; end
            5'b00110: begin r.aop = 4'd7; r.res = x ^ y; end
            5'b00111: begin r.aop = 4'd1; r.res = x - y; r.wb = 1'b0; end
            5'b01000: begin r.aop = 4'd6; r.res = x; r.eb = '0; r.fl = 1'b0; end
            5'b01001: begin r.aop = 4'd8; r.res = (x == y) ? 16'd1 : 16'd0; end
            5'b11010: begin r.aop = 4'd2; r.res = x << y; end
            5'b11011: begin r.aop = 4'd4; r.res = x >> y; end
            5'b11100: begin r.aop = 4'd3; r.res = $signed(x) >>> y; end
            default:  r = '0;
        endcase
        return r;
    endfunction

    mres_t mres;
    assign mres = model_fn(instr[15:11], m_reg[instr[10:8]], m_reg[instr[7:5]]);

    // Timeline: interval n is the cycle following clock edge n.
    int           cyc = 0;
    int           m_ready_edge = 0, m_acc_cnt = 0;
    int           we_at = -10, fl_at = -10, ill_at = -10, op_at = -10;
    logic [2:0]   w_addr;
    logic [W-1:0] w_data, e_a, e_b;
    logic [3:0]   e_op;
    logic         pf_z, pf_n, m_z = 1'b0, m_n = 1'b0;
    logic         pl_en = 1'b0;
    logic [2:0]   pl_addr;
    logic [W-1:0] pl_val;
    int           acc_e [16];
    int           acc_n = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pl_en)      rf[pl_addr] <= pl_val;
        else if (rf_we) rf[rf_waddr] <= rf_wdata;
        if (!rst && instr_valid && instr_ready) begin
            acc_e[acc_n % 16] <= cyc + 1;
            acc_n <= acc_n + 1;
        end
        if (rst) begin
            m_ready_edge <= 0;
            we_at <= -10; fl_at <= -10; ill_at <= -10; op_at <= -10;
            m_z <= 1'b0; m_n <= 1'b0;
            if (pl_en) m_reg[pl_addr] <= pl_val;
        end else begin
            if (pl_en)             m_reg[pl_addr] <= pl_val;
            else if (cyc == we_at) m_reg[w_addr] <= w_data;
            if (cyc + 1 == fl_at) begin m_z <= pf_z; m_n <= pf_n; end
            if (instr_valid && cyc + 1 >= m_ready_edge) begin
                m_acc_cnt <= m_acc_cnt + 1;
                if (mres.legal) begin
                    m_ready_edge <= cyc + 5;
                    we_at  <= mres.wb ? cyc + 3 : -10;
                    fl_at  <= mres.fl ? cyc + 4 : -10;
                    w_addr <= instr[10:8];
                    w_data <= mres.res;
                    pf_z   <= (mres.res == '0);
                    pf_n   <= mres.res[W-1];
                    op_at  <= cyc + 2;
                    e_a <= mres.ea; e_b <= mres.eb; e_op <= mres.aop;
                end else begin
                    ill_at <= cyc + 1;
                    m_ready_edge <= cyc + 2;
                end
            end
        end
    end

    // Checking
    int checks = 0, errors = 0;
    int we_cnt = 0, ill_cnt = 0;
    int pin_at = -1, pin_kind = 0, pin_we0 = 0, pin_ill0 = 0, pin_dwe = 0, pin_dill = 0, pin_b0 = 0;
    logic [2:0]   pin_reg;
    logic [W-1:0] pin_val;
    logic         pin_z, pin_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("rst_ready",   32'(instr_ready), 32'd1);
            chk("rst_we",      32'(rf_we), 32'd0);
            chk("rst_illegal", 32'(illegal), 32'd0);
            chk("rst_flags",   32'({flag_z, flag_n}), 32'd0);
            chk("rst_op",      32'(alu_op), 32'd0);
            chk("rst_ab",      {alu_a, alu_b}, 32'd0);
        end else begin
            if (rf_we)   we_cnt++;
            if (illegal) ill_cnt++;
            chk("ready",   32'(instr_ready), 32'(cyc >= m_ready_edge - 1));
            chk("rf_we",   32'(rf_we), 32'(cyc == we_at));
            chk("illegal", 32'(illegal), 32'(cyc == ill_at));
            chk("flag_z",  32'(flag_z), 32'(m_z));
            chk("flag_n",  32'(flag_n), 32'(m_n));
            if (cyc == we_at) begin
                chk("waddr", 32'(rf_waddr), 32'(w_addr));
                chk("wdata", 32'(rf_wdata), 32'(w_data));
            end
            if (cyc == op_at || cyc == op_at + 1) begin
                chk("alu_a",  32'(alu_a), 32'(e_a));
                chk("alu_b",  32'(alu_b), 32'(e_b));
                chk("alu_op", 32'(alu_op), 32'(e_op));
            end
            if (cyc == pin_at && pin_kind == 1) begin
                chk("pin_reg",   32'(rf[pin_reg]), 32'(pin_val));
                chk("pin_z",     32'(flag_z), 32'(pin_z));
                chk("pin_n",     32'(flag_n), 32'(pin_n));
                chk("pin_we",    32'(we_cnt - pin_we0), 32'(pin_dwe));
                chk("pin_ill",   32'(ill_cnt - pin_ill0), 32'(pin_dill));
                chk("pin_ready", 32'(instr_ready), 32'd1);
            end
            if (cyc == pin_at && pin_kind == 2) begin
                chk("b2b_count", 32'(acc_n - pin_b0), 32'd3);
                chk("b2b_gap1",  32'(acc_e[(pin_b0 + 1) % 16] - acc_e[pin_b0 % 16]), 32'd4);
                chk("b2b_gap2",  32'(acc_e[(pin_b0 + 2) % 16] - acc_e[(pin_b0 + 1) % 16]), 32'd4);
            end
        end
    end

    // Stimulus (all changes land 1 time unit after a falling edge)
    function automatic logic [15:0] enc(input logic [4:0] op, input logic [2:0] x,
                                        input logic [2:0] y);
        return {op, x, y, 5'd0};
    endfunction

    task automatic preload(input logic [2:0] a, input logic [W-1:0] v);
        pl_addr = a; pl_val = v; pl_en = 1'b1;
        @(negedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic [15:0] w, input bit keep);
        int  s;
        bit  ok;
        s = m_acc_cnt; ok = 1'b0;
        instr_valid = 1'b1; instr = w;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (m_acc_cnt != s) begin ok = 1'b1; break; end
        end
        #1;
        if (!ok) begin
            $display("FAIL accept_timeout at %0t: actual=none required=accept", $time);
            $fatal(1, "no accept");
        end
        if (!keep) instr_valid = 1'b0;
    endtask

    task automatic directed(input logic [15:0] w, input logic [2:0] r, input logic [W-1:0] v,
                            input logic z, input logic n, input int dwe, input int dill);
        pin_we0 = we_cnt; pin_ill0 = ill_cnt;
        issue(w, 1'b0);
        pin_reg = r; pin_val = v; pin_z = z; pin_n = n; pin_dwe = dwe; pin_dill = dill;
        pin_kind = 1; pin_at = cyc + 3;
        repeat (4) @(negedge clk);
        #1;
    endtask

    logic [4:0] legal_ops [11] = '{5'b00001, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                                   5'b01000, 5'b01001, 5'b11010, 5'b11011, 5'b11100};

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr = '0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;

        preload(3'd0, 16'h1234); preload(3'd1, 16'h0005); preload(3'd2, 16'h0003);
        preload(3'd3, 16'hFFFF); preload(3'd4, 16'h0001); preload(3'd5, 16'h0000);
        preload(3'd6, 16'h8000); preload(3'd7, 16'h0004);

        directed(16'h0940, 3'd1, 16'h0008, 1'b0, 1'b0, 1, 0);            // ADD R1,R2
        preload(3'd1, 16'h0003); preload(3'd2, 16'h0005);
        directed(enc(5'b00011, 1, 2), 3'd1, 16'hFFFE, 1'b0, 1'b1, 1, 0); // SUB R1,R2
        directed(enc(5'b00111, 1, 1), 3'd1, 16'hFFFE, 1'b1, 1'b0, 0, 0); // CMP R1,R1
        directed(enc(5'b00001, 3, 4), 3'd3, 16'h0000, 1'b1, 1'b0, 1, 0); // ADD wrap
        directed(16'hF800, 3'd0, 16'h1234, 1'b1, 1'b0, 0, 1);            // illegal
        directed(enc(5'b00001, 1, 2), 3'd1, 16'h0003, 1'b0, 1'b0, 1, 0); // ADD after illegal

        pin_b0 = acc_n;
        issue(enc(5'b00001, 1, 2), 1'b1);
        issue(enc(5'b00001, 1, 2), 1'b1);
        issue(enc(5'b00001, 1, 2), 1'b0);
        repeat (5) @(negedge clk);
        #1 pin_kind = 2; pin_at = cyc + 1;
        repeat (2) @(negedge clk);
        #1;

        directed(enc(5'b00111, 1, 1), 3'd1, 16'h0012, 1'b1, 1'b0, 0, 0); // CMP sets Z
        preload(3'd1, 16'h0005); preload(3'd2, 16'h0003);
        pin_we0 = we_cnt; pin_ill0 = ill_cnt;
        issue(enc(5'b00001, 1, 2), 1'b0);
        @(negedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        pin_reg = 3'd1; pin_val = 16'h0005; pin_z = 1'b0; pin_n = 1'b0; pin_dwe = 0; pin_dill = 0;
        pin_kind = 1; pin_at = cyc + 1;
        repeat (2) @(negedge clk);
        #1;

        for (int n = 0; n < 300; n++) begin
            logic [4:0] opc;
            bit         keep;
            if (n % 60 == 0) begin
                instr_valid = 1'b0;
                repeat (5) @(negedge clk);
                #1;
                for (int r = 0; r < 8; r++) begin
                    case ($urandom_range(0, 3))
                        0:       preload(3'(r), 16'($urandom_range(0, 20)));
                        1:       preload(3'(r), ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'hFFFF);
                        default: preload(3'(r), 16'($urandom));
                    endcase
                end
            end
            opc  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                               : legal_ops[$urandom_range(0, 10)];
            keep = ($urandom_range(0, 3) == 0);
            issue({opc, 3'($urandom), 3'($urandom), 5'($urandom)}, keep);
            if (!keep) begin
                repeat ($urandom_range(0, 4)) @(negedge clk);
                #1;
            end
        end
        instr_valid = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
